// File: rtl/mu0_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// mu0_ctrl_fsm -- MU0 control unit with memory wait states, optional AND/OR,
// bus watchdog and sticky HALT status.
//
// Sequences FETCH/EXEC for the PC/IR/ACC/ALU/memory datapath. All state
// changes happen on the rising edge of clk. Reset is synchronous, active-low.
//
// Optional build macro: MU0_CTRL_ICOUNT_EN adds the instr_count output, which
// counts completed EXEC cycles (wraps at 2**CNT_W, frozen in HALT).
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   in_opcode[OPC_W]    IR opcode field; any bit above bit 3 set -> illegal
//   acc_15, accz        ACC sign / ACC==0 flags, used by JGE / JNE
//   mem_ready           memory finishes the current access this cycle
//   a_sel, b_sel        address mux (0 PC, 1 IR), ALU B mux (0 addr, 1 mem)
//   pc_ce, ir_ce,
//   acc_ce, acc_oe      datapath enables
//   alufs[3]            0 idle, 1 ADD, 2 SUB, 3 PASS B, 4 INC A, 5 AND, 6 OR
//   rnw, memrq          1 = read / memory request
//   halted              core is in HALT
//   illegal, bus_err    HALT cause: illegal opcode / watchdog timeout
//   instr_count[CNT_W]  completed instructions (MU0_CTRL_ICOUNT_EN only)
// -----------------------------------------------------------------------------
module mu0_ctrl_fsm #(
  parameter int OPC_W      = 4,
  parameter int EXT_OPS    = 1,
  parameter int WAIT_LIMIT = 0,
  parameter int WDT_W      = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPC_W-1:0] in_opcode,
  input  logic             acc_15,
  input  logic             accz,
  input  logic             mem_ready,
  output logic             a_sel,
  output logic             b_sel,
  output logic             pc_ce,
  output logic             ir_ce,
  output logic             acc_ce,
  output logic             acc_oe,
  output logic [2:0]       alufs,
  output logic             rnw,
  output logic             memrq,
  output logic             halted,
  output logic             illegal,
  output logic             bus_err
`ifdef MU0_CTRL_ICOUNT_EN
  ,
  output logic [CNT_W-1:0] instr_count
`endif
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  localparam int               LIM_M1_I = (WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0;
  localparam logic [WDT_W-1:0] LIM_M1   = LIM_M1_I[WDT_W-1:0];

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;
  logic [WDT_W-1:0] wdt_q, wdt_d;

  // ---------------------------------------------------------------------------
  // Opcode decode
  // ---------------------------------------------------------------------------
  logic [3:0] op;
  logic       hi_set;
  logic       op_load, op_sto, op_jmp, op_stop, op_ill, jmp_taken;
  logic [2:0] ld_fn;

  assign op = in_opcode[3:0];

  generate
    if (OPC_W > 4) begin : g_hi
      assign hi_set = |in_opcode[OPC_W-1:4];
    end else begin : g_nohi
      assign hi_set = 1'b0;
    end
  endgenerate

  always_comb begin
    op_load   = 1'b0;
    op_sto    = 1'b0;
    op_jmp    = 1'b0;
    op_stop   = 1'b0;
    op_ill    = 1'b0;
    jmp_taken = 1'b0;
    ld_fn     = 3'd0;
    if (hi_set) begin
      op_ill = 1'b1;
    end else begin
      case (op)
        4'd0: begin op_load = 1'b1; ld_fn = 3'd3; end
        4'd1: op_sto = 1'b1;
        4'd2: begin op_load = 1'b1; ld_fn = 3'd1; end
        4'd3: begin op_load = 1'b1; ld_fn = 3'd2; end
        4'd4: begin op_jmp = 1'b1; jmp_taken = 1'b1;    end
        4'd5: begin op_jmp = 1'b1; jmp_taken = ~acc_15; end
        4'd6: begin op_jmp = 1'b1; jmp_taken = ~accz;   end
        4'd7: op_stop = 1'b1;
        4'd8: begin
          if (EXT_OPS != 0) begin op_load = 1'b1; ld_fn = 3'd5; end
          else              op_ill  = 1'b1;
        end
        4'd9: begin
          if (EXT_OPS != 0) begin op_load = 1'b1; ld_fn = 3'd6; end
          else              op_ill  = 1'b1;
        end
        default: op_ill = 1'b1;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode. Enables are gated by mem_ready, so a stall holds every
  // output stable and nothing fires until the access completes.
  // ---------------------------------------------------------------------------
  always_comb begin
    a_sel  = 1'b0;
    b_sel  = 1'b0;
    pc_ce  = 1'b0;
    ir_ce  = 1'b0;
    acc_ce = 1'b0;
    acc_oe = 1'b0;
    alufs  = 3'd0;
    rnw    = 1'b1;
    memrq  = 1'b0;
    case (state_q)
      S_FETCH: begin
        memrq = 1'b1;
        alufs = 3'd4;
        pc_ce = mem_ready;
        ir_ce = mem_ready;
      end
      S_EXEC: begin
        if (op_load) begin
          a_sel  = 1'b1;
          b_sel  = 1'b1;
          memrq  = 1'b1;
          alufs  = ld_fn;
          acc_ce = mem_ready;
        end else if (op_sto) begin
          a_sel  = 1'b1;
          acc_oe = 1'b1;
          memrq  = 1'b1;
          rnw    = 1'b0;
        end else if (op_jmp) begin
          // Taken: fetch the target via IR operand. Not taken: fetch the
          // next sequential word via PC. Either way IR gets the next opcode
          // and PC = address+1, so EXEC runs again directly.
          a_sel = jmp_taken;
          memrq = 1'b1;
          alufs = 3'd4;
          pc_ce = mem_ready;
          ir_ce = mem_ready;
        end
      end
      default: ;
    endcase
  end

  assign halted  = (state_q == S_HALT);
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;

  // ---------------------------------------------------------------------------
  // Watchdog. The count includes the current stalled cycle: the timeout fires
  // on the WAIT_LIMIT-th consecutive stalled cycle. A ready cycle never times
  // out, so a completion on that cycle proceeds normally.
  // ---------------------------------------------------------------------------
  logic stall, timeout;

  assign stall   = memrq & ~mem_ready;
  assign timeout = (WAIT_LIMIT > 0) && stall && (wdt_q == LIM_M1);

  always_comb begin
    wdt_d = '0;
    if ((WAIT_LIMIT > 0) && stall) wdt_d = wdt_q + WDT_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    case (state_q)
      S_FETCH: begin
        if (timeout) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end else if (mem_ready) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op_stop) begin
          state_d = S_HALT;
        end else if (op_ill) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else if (timeout) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end else if (mem_ready && (op_load || op_sto)) begin
          state_d = S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      wdt_q     <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      wdt_q     <= wdt_d;
    end
  end

`ifdef MU0_CTRL_ICOUNT_EN
  // ---------------------------------------------------------------------------
  // Completed-instruction counter: memory ops and jumps complete with
  // mem_ready, STOP completes unconditionally. Illegal opcodes do not count.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done;

  assign done = (state_q == S_EXEC) &&
                (op_stop || (mem_ready && (op_load || op_sto || op_jmp)));

  always_comb begin
    cnt_d = cnt_q;
    if (done) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign instr_count = cnt_q;
`endif

endmodule

// File: tb/tb_mu0_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_mu0_ctrl_fsm -- directed bench for mu0_ctrl_fsm.
// Two instances share all inputs:
//   dut_m : EXT_OPS=1, watchdog off, CNT_W=16
//   dut_w : EXT_OPS=0, WAIT_LIMIT=4, CNT_W=4
// Outputs are packed into one 16-bit word per instance and compared against
// hand-written expected words.
// -----------------------------------------------------------------------------
module tb_mu0_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_opcode;
  logic       acc_15, accz, mem_ready;

  logic       a_m, b_m, pc_m, ir_m, ac_m, oe_m, rw_m, mq_m, h_m, il_m, be_m;
  logic [2:0] alu_m;
  logic       a_w, b_w, pc_w, ir_w, ac_w, oe_w, rw_w, mq_w, h_w, il_w, be_w;
  logic [2:0] alu_w;
`ifdef MU0_CTRL_ICOUNT_EN
  logic [15:0] cnt_m;
  logic [3:0]  cnt_w;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mu0_ctrl_fsm #(.OPC_W(4), .EXT_OPS(1), .WAIT_LIMIT(0), .WDT_W(8), .CNT_W(16)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_opcode(in_opcode), .acc_15(acc_15), .accz(accz),
    .mem_ready(mem_ready), .a_sel(a_m), .b_sel(b_m), .pc_ce(pc_m), .ir_ce(ir_m),
    .acc_ce(ac_m), .acc_oe(oe_m), .alufs(alu_m), .rnw(rw_m), .memrq(mq_m),
    .halted(h_m), .illegal(il_m), .bus_err(be_m)
`ifdef MU0_CTRL_ICOUNT_EN
    , .instr_count(cnt_m)
`endif
  );

  mu0_ctrl_fsm #(.OPC_W(4), .EXT_OPS(0), .WAIT_LIMIT(4), .WDT_W(8), .CNT_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_opcode(in_opcode), .acc_15(acc_15), .accz(accz),
    .mem_ready(mem_ready), .a_sel(a_w), .b_sel(b_w), .pc_ce(pc_w), .ir_ce(ir_w),
    .acc_ce(ac_w), .acc_oe(oe_w), .alufs(alu_w), .rnw(rw_w), .memrq(mq_w),
    .halted(h_w), .illegal(il_w), .bus_err(be_w)
`ifdef MU0_CTRL_ICOUNT_EN
    , .instr_count(cnt_w)
`endif
  );

  logic [15:0] om, ow;
  assign om = {2'b00, a_m, b_m, pc_m, ir_m, ac_m, oe_m, alu_m, rw_m, mq_m, h_m, il_m, be_m};
  assign ow = {2'b00, a_w, b_w, pc_w, ir_w, ac_w, oe_w, alu_w, rw_w, mq_w, h_w, il_w, be_w};

  // Expected output word, same field order as om/ow.
  function automatic logic [15:0] ev(input logic a, b, pc, ir, ac, oe,
                                     input logic [2:0] alu,
                                     input logic rw, mq, h, il, be);
    return {2'b00, a, b, pc, ir, ac, oe, alu, rw, mq, h, il, be};
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%04h exp=%04h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [3:0] op, input logic rdy, input logic a15, input logic z);
    in_opcode = op;
    mem_ready = rdy;
    acc_15    = a15;
    accz      = z;
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  logic [15:0] FETCH_R, FETCH_S, IDLE, LDA_R, LDA_S, JT, JN;

  initial begin
    FETCH_R = ev(0,0,1,1,0,0,3'd4,1,1,0,0,0);
    FETCH_S = ev(0,0,0,0,0,0,3'd4,1,1,0,0,0);
    IDLE    = ev(0,0,0,0,0,0,3'd0,1,0,0,0,0);
    LDA_R   = ev(1,1,0,0,1,0,3'd3,1,1,0,0,0);
    LDA_S   = ev(1,1,0,0,0,0,3'd3,1,1,0,0,0);
    JT      = ev(1,0,1,1,0,0,3'd4,1,1,0,0,0);
    JN      = ev(0,0,1,1,0,0,3'd4,1,1,0,0,0);

    rst_n = 1'b0;
    in_opcode = 4'd0; acc_15 = 1'b0; accz = 1'b0; mem_ready = 1'b1;
    step(); step();
    rst_n = 1'b1; #1;
    chk("rst_m", om, FETCH_R);
    chk("rst_w", ow, FETCH_R);

    // T1: LDA / ADD / SUB / STO / STOP with memory always ready
    step(); drv(4'd0, 1, 0, 0);
    chk("t1_lda_m", om, LDA_R);
    chk("t1_lda_w", ow, LDA_R);
    step(); chk("t1_f1", om, FETCH_R);
    step(); drv(4'd2, 1, 0, 0);
    chk("t1_add", om, ev(1,1,0,0,1,0,3'd1,1,1,0,0,0));
    step(); chk("t1_f2", om, FETCH_R);
    step(); drv(4'd3, 1, 0, 0);
    chk("t1_sub", om, ev(1,1,0,0,1,0,3'd2,1,1,0,0,0));
    step(); chk("t1_f3", om, FETCH_R);
    step(); drv(4'd1, 1, 0, 0);
    chk("t1_sto", om, ev(1,0,0,0,0,1,3'd0,0,1,0,0,0));
    step(); chk("t1_f4", om, FETCH_R);
    step(); drv(4'd7, 1, 0, 0);
    chk("t1_stop_m", om, IDLE);
    chk("t1_stop_w", ow, IDLE);
    step();
    chk("t1_halt_m", om, ev(0,0,0,0,0,0,3'd0,1,0,1,0,0));
    chk("t1_halt_w", ow, ev(0,0,0,0,0,0,3'd0,1,0,1,0,0));
    step(); drv(4'd0, 1, 0, 0);
    chk("t1_halt_hold", om, ev(0,0,0,0,0,0,3'd0,1,0,1,0,0));

    // T6a: reset out of HALT
    do_reset();
    chk("t6_rst_halt", om, FETCH_R);
`ifdef MU0_CTRL_ICOUNT_EN
    chk("t6_cnt0_m", cnt_m, 16'd0);
`endif

    // T2: conditional jumps, state stays EXEC after every jump
    step(); drv(4'd5, 1, 0, 0); chk("t2_jge_t", om, JT);
    step(); drv(4'd5, 1, 1, 0); chk("t2_jge_n", om, JN);
    step(); drv(4'd6, 1, 0, 1); chk("t2_jne_n", om, JN);
    step(); drv(4'd6, 1, 0, 0); chk("t2_jne_t", om, JT);
    step(); drv(4'd4, 1, 1, 1); chk("t2_jmp", om, JT);
    step(); drv(4'd0, 1, 0, 0); chk("t2_exec", om, LDA_R);
    step(); chk("t2_f", om, FETCH_R);

    // T3: three stalled cycles on LDA
    step(); drv(4'd0, 0, 0, 0); chk("t3_s1", om, LDA_S);
    step(); chk("t3_s2", om, LDA_S);
    step(); chk("t3_s3_m", om, LDA_S);
    chk("t3_s3_w", ow, LDA_S);
    drv(4'd0, 1, 0, 0); chk("t3_rdy", om, LDA_R);
    step();
    chk("t3_f_m", om, FETCH_R);
    chk("t3_f_w", ow, FETCH_R);

    // T5: AND/OR legal on dut_m, 8 illegal on dut_w, 4'hC illegal on dut_m
    step(); drv(4'd8, 1, 0, 0);
    chk("t5_and_m", om, ev(1,1,0,0,1,0,3'd5,1,1,0,0,0));
    chk("t5_ill8_w", ow, IDLE);
    step();
    chk("t5_f_m", om, FETCH_R);
    chk("t5_halt_w", ow, ev(0,0,0,0,0,0,3'd0,1,0,1,1,0));
    step(); drv(4'd9, 1, 0, 0);
    chk("t5_or_m", om, ev(1,1,0,0,1,0,3'd6,1,1,0,0,0));
    chk("t5_hold_w", ow, ev(0,0,0,0,0,0,3'd0,1,0,1,1,0));
    step(); chk("t5_f2_m", om, FETCH_R);
    step(); drv(4'hC, 1, 0, 0);
    chk("t5_illc_m", om, IDLE);
    step();
    chk("t5_haltc_m", om, ev(0,0,0,0,0,0,3'd0,1,0,1,1,0));
    do_reset();
    chk("t5_rst_w", ow, FETCH_R);

    // T4: stuck in FETCH, watchdog fires on the 4th stalled cycle
    drv(4'd0, 0, 0, 0);
    chk("t4_s1", ow, FETCH_S);
    step(); chk("t4_s2", ow, FETCH_S);
    step(); chk("t4_s3", ow, FETCH_S);
    step(); chk("t4_s4", ow, FETCH_S);
    step();
    chk("t4_berr_w", ow, ev(0,0,0,0,0,0,3'd0,1,0,1,0,1));
    chk("t4_nowdt_m", om, FETCH_S);
    step(); chk("t4_hold_w", ow, ev(0,0,0,0,0,0,3'd0,1,0,1,0,1));
    do_reset();
    chk("t4_rst_w", ow, FETCH_S);

    // Ready on the limit cycle completes; the count restarts afterwards
    step(); step(); step();
    drv(4'd0, 1, 0, 0); chk("t4_lim_rdy", ow, FETCH_R);
    step(); drv(4'd0, 0, 0, 0); chk("t4_ex_s1", ow, LDA_S);
    step(); step();
    chk("t4_ex_s3", ow, LDA_S);
    drv(4'd0, 1, 0, 0); chk("t4_ex_rdy", ow, LDA_R);
    step(); chk("t4_ex_f", ow, FETCH_R);

    // T6b: reset in the middle of a stalled LDA
    step(); drv(4'd0, 0, 0, 0); chk("t6_pre", om, LDA_S);
    do_reset();
    chk("t6_mid_m", om, FETCH_S);
    chk("t6_mid_w", ow, FETCH_S);

`ifdef MU0_CTRL_ICOUNT_EN
    chk("t6_cnt0_w", {12'd0, cnt_w}, 16'd0);
    drv(4'd0, 1, 0, 0);
    step();
    for (int i = 1; i <= 16; i++) begin
      drv(4'd4, 1, 0, 0);
      step();
      chk("t6_cnt_w", {12'd0, cnt_w}, 16'(i % 16));
    end
    chk("t6_cnt16_m", cnt_m, 16'd16);
    drv(4'd7, 0, 0, 0);
    step();
    chk("t6_stop_m", cnt_m, 16'd17);
    drv(4'd4, 1, 0, 0);
    step();
    chk("t6_frozen_m", cnt_m, 16'd17);
    chk("t6_frozen_w", {12'd0, cnt_w}, 16'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
